// File: rtl/bus_arbiter_rr_if.sv
// Request/grant handshake and bus-tracking signals shared by the DMA masters and bus_arbiter_rr.
interface bus_arbiter_rr_if #(
    parameter int NR_MASTERS = 4
);
    logic [NR_MASTERS-1:0] requestTransaction;
    logic [NR_MASTERS-1:0] transactionGranted;
    logic                  beginTransactionIn;
    logic                  endTransactionIn;
    logic                  busErrorIn;
    logic [2:0]            grantIndex;
    logic                  busOwned;
    logic                  endTransactionOut;
    logic                  busErrorOut;
    logic                  watchdogFlag;

    modport master (
        output requestTransaction, beginTransactionIn, endTransactionIn, busErrorIn,
        input  transactionGranted, grantIndex, busOwned,
        input  endTransactionOut, busErrorOut, watchdogFlag
    );

    modport slave (
        input  requestTransaction, beginTransactionIn, endTransactionIn, busErrorIn,
        output transactionGranted, grantIndex, busOwned,
        output endTransactionOut, busErrorOut, watchdogFlag
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: one registered grant pulse per transaction, tracks begin/end, releases the bus.
// Optional BUSY watchdog enabled by defining BUS_ARB_WATCHDOG_EN.
module bus_arbiter_rr #(
    parameter int NR_MASTERS      = 4,
    parameter int BEGIN_TIMEOUT   = 16,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input logic             clock,
    input logic             reset,
    bus_arbiter_rr_if.slave bus
);
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WAIT_BEGIN,
        BUSY,
        RELEASE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IDX_W-1:0]      last_owner;
    logic [IDX_W-1:0]      last_owner_next;
    logic [IDX_W-1:0]      grant_index;
    logic [IDX_W-1:0]      grant_index_next;
    logic [NR_MASTERS-1:0] granted;
    logic [NR_MASTERS-1:0] granted_next;
    logic                  owned;
    logic                  owned_next;
    logic [4:0]            begin_cnt;
    logic [4:0]            begin_cnt_next;
    logic                  found;
    logic [IDX_W-1:0]      winner;

    // A bus error only marks the transfer; the master still closes it with an end strobe.
    logic unused_bus_error;
    assign unused_bus_error = bus.busErrorIn;

`ifdef BUS_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES) + 1;

    logic [WD_W-1:0] wd_cnt;
    logic [WD_W-1:0] wd_cnt_next;
    logic            wd_fire;
    logic            wd_pulse;
    logic            wd_flag;
`endif

    // First requester after the previous owner, wrapping modulo NR_MASTERS.
    always_comb begin : arbitrate
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NR_MASTERS; k++) begin
            idx = (int'(last_owner) + k) % NR_MASTERS;
            if (!found && bus.requestTransaction[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_next       = state;
        last_owner_next  = last_owner;
        grant_index_next = grant_index;
        granted_next     = '0;
        begin_cnt_next   = begin_cnt;
`ifdef BUS_ARB_WATCHDOG_EN
        wd_cnt_next      = wd_cnt;
        wd_fire          = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_next       = GRANT;
                    last_owner_next  = winner;
                    grant_index_next = winner;
                    granted_next     = NR_MASTERS'(1) << winner;
                end
            end
            GRANT: begin
                state_next     = WAIT_BEGIN;
                begin_cnt_next = '0;
            end
            WAIT_BEGIN: begin
                if (bus.beginTransactionIn) begin
                    state_next = BUSY;
`ifdef BUS_ARB_WATCHDOG_EN
                    wd_cnt_next = '0;
`endif
                end else if (begin_cnt >= 5'(BEGIN_TIMEOUT - 1)) begin
                    state_next = RELEASE;
                end else if (begin_cnt != 5'h1f) begin
                    begin_cnt_next = begin_cnt + 5'd1;
                end
            end
            BUSY: begin
                if (bus.endTransactionIn) begin
                    state_next = RELEASE;
`ifdef BUS_ARB_WATCHDOG_EN
                end else if (wd_cnt >= WD_W'(WATCHDOG_CYCLES - 1)) begin
                    state_next = RELEASE;
                    wd_fire    = 1'b1;
                end else begin
                    wd_cnt_next = wd_cnt + WD_W'(1);
`endif
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign owned_next = (state_next == GRANT) || (state_next == WAIT_BEGIN) || (state_next == BUSY);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_owner  <= IDX_W'(NR_MASTERS - 1);
            grant_index <= '0;
            granted     <= '0;
            owned       <= 1'b0;
            begin_cnt   <= '0;
        end else begin
            state       <= state_next;
            last_owner  <= last_owner_next;
            grant_index <= grant_index_next;
            granted     <= granted_next;
            owned       <= owned_next;
            begin_cnt   <= begin_cnt_next;
        end
    end

    assign bus.transactionGranted = granted;
    assign bus.grantIndex         = grant_index;
    assign bus.busOwned           = owned;

`ifdef BUS_ARB_WATCHDOG_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt   <= '0;
            wd_pulse <= 1'b0;
            wd_flag  <= 1'b0;
        end else begin
            wd_cnt   <= wd_cnt_next;
            wd_pulse <= wd_fire;
            wd_flag  <= wd_flag | wd_fire;
        end
    end

    assign bus.endTransactionOut = wd_pulse;
    assign bus.busErrorOut       = wd_pulse;
    assign bus.watchdogFlag      = wd_flag;
`else
    assign bus.endTransactionOut = 1'b0;
    assign bus.busErrorOut       = 1'b0;
    assign bus.watchdogFlag      = 1'b0;
`endif
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: vector table, hand-written corner sequences, randomized transactions.
module tb_bus_arbiter_rr;
    localparam int N      = 4;
    localparam int BEGIN_TIMEOUT = 16;
    localparam int WD_CYC = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    bus_arbiter_rr_if #(.NR_MASTERS(N)) bus ();

    bus_arbiter_rr #(
        .NR_MASTERS      (N),
        .BEGIN_TIMEOUT   (BEGIN_TIMEOUT),
        .WATCHDOG_CYCLES (WD_CYC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        int         bdelay;
        int         edelay;
    } vec_t;

    vec_t table_v [12];
    int   checks   = 0;
    int   failures = 0;
    int   model_last;
    logic exp_flag;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic o, input int idx);
        check({tag, ".grant"}, 32'(bus.transactionGranted), 32'(g));
        check({tag, ".owned"}, 32'(bus.busOwned), 32'(o));
        check({tag, ".index"}, 32'(bus.grantIndex), 32'(idx));
        check({tag, ".wd_outs"},
              {29'd0, bus.endTransactionOut, bus.busErrorOut, bus.watchdogFlag},
              {29'd0, 2'b00, exp_flag});
    endtask

    // Reference rule: rotate the request vector so the master after the last owner sits at bit 0,
    // then the lowest set bit of the rotated vector is the winner.
    function automatic int rr_pick(input logic [3:0] req, input int last);
        logic [7:0] twice;
        logic [3:0] rot;
        twice = {req, req};
        rot   = twice[((last + 1) % N) +: 4];
        for (int b = 0; b < N; b++)
            if (rot[b]) return (last + 1 + b) % N;
        return -1;
    endfunction

    // One full transaction starting from IDLE; leaves the arbiter in IDLE.
    task automatic run_txn(input logic [3:0] req, input logic [3:0] exp_grant, input int bdelay,
                           input int edelay, input bit timeout, input bit err, input bit same_end);
        int exp_idx;
        exp_idx = 0;
        for (int b = 0; b < N; b++)
            if (exp_grant[b]) exp_idx = b;
        bus.requestTransaction = req;
        step();
        check_outs("grant", exp_grant, 1'b1, exp_idx);
        model_last = exp_idx;
        bus.requestTransaction = 4'($urandom);
        step();
        check_outs("pulse_end", 4'b0000, 1'b1, exp_idx);
        if (timeout) begin
            for (int i = 1; i < BEGIN_TIMEOUT; i++) begin
                step();
                check_outs("wait_begin", 4'b0000, 1'b1, exp_idx);
            end
            step();
            check_outs("begin_timeout", 4'b0000, 1'b0, exp_idx);
        end else begin
            for (int i = 0; i < bdelay; i++) begin
                step();
                check_outs("wait_begin", 4'b0000, 1'b1, exp_idx);
            end
            bus.beginTransactionIn = 1'b1;
            bus.endTransactionIn   = same_end;
            step();
            bus.beginTransactionIn = 1'b0;
            bus.endTransactionIn   = 1'b0;
            check_outs("busy", 4'b0000, 1'b1, exp_idx);
            bus.busErrorIn = err;
            for (int i = 0; i < edelay; i++) begin
                step();
                check_outs("busy_hold", 4'b0000, 1'b1, exp_idx);
            end
            bus.busErrorIn       = 1'b0;
            bus.endTransactionIn = 1'b1;
            step();
            bus.endTransactionIn = 1'b0;
            check_outs("release", 4'b0000, 1'b0, exp_idx);
        end
        step();
        check_outs("idle", 4'b0000, 1'b0, exp_idx);
        bus.requestTransaction = 4'b0000;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        table_v[0]  = '{4'b1111, 4'b0010, 0, 1};
        table_v[1]  = '{4'b1111, 4'b0100, 0, 1};
        table_v[2]  = '{4'b1111, 4'b1000, 0, 1};
        table_v[3]  = '{4'b1111, 4'b0001, 0, 1};
        table_v[4]  = '{4'b0010, 4'b0010, 2, 0};
        table_v[5]  = '{4'b1010, 4'b1000, 1, 2};
        table_v[6]  = '{4'b1010, 4'b0010, 0, 0};
        table_v[7]  = '{4'b0001, 4'b0001, 3, 1};
        table_v[8]  = '{4'b1000, 4'b1000, 0, 4};
        table_v[9]  = '{4'b0110, 4'b0010, 1, 1};
        table_v[10] = '{4'b0110, 4'b0100, 0, 0};
        table_v[11] = '{4'b0101, 4'b0001, 2, 2};

        exp_flag               = 1'b0;
        bus.requestTransaction = 4'b0000;
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b0;
        bus.busErrorIn         = 1'b0;
        repeat (3) step();
        check_outs("reset", 4'b0000, 1'b0, 0);
        reset = 1'b1;

        // Reset in the middle of BUSY must clear everything and restore master 0 priority.
        bus.requestTransaction = 4'b1111;
        step();
        check_outs("pre_reset_grant", 4'b0001, 1'b1, 0);
        step();
        bus.beginTransactionIn = 1'b1;
        step();
        bus.beginTransactionIn = 1'b0;
        step();
        check_outs("pre_reset_busy", 4'b0000, 1'b1, 0);
        #3 reset = 1'b0;
        #1;
        check_outs("async_reset", 4'b0000, 1'b0, 0);
        step();
        check_outs("reset_held", 4'b0000, 1'b0, 0);
        reset      = 1'b1;
        model_last = N - 1;
        run_txn(4'b1111, 4'b0001, 0, 1, 1'b0, 1'b0, 1'b0);

        for (int v = 0; v < 12; v++)
            run_txn(table_v[v].req, table_v[v].grant, table_v[v].bdelay, table_v[v].edelay,
                    1'b0, 1'b0, 1'b0);

        // Begin timeout abandons the grant; the next requester follows.
        run_txn(4'b1111, 4'b0010, 0, 0, 1'b1, 1'b0, 1'b0);
        run_txn(4'b1111, 4'b0100, 0, 0, 1'b0, 1'b0, 1'b0);

        // Bus error holds ownership until end arrives three cycles later.
        run_txn(4'b1111, 4'b1000, 0, 3, 1'b0, 1'b1, 1'b0);

        // Begin and end together: end is ignored outside BUSY.
        run_txn(4'b0011, 4'b0001, 1, 2, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] req;
            if ($urandom_range(0, 3) == 0) begin
                bus.requestTransaction = 4'b0000;
                repeat ($urandom_range(1, 3)) begin
                    step();
                    check_outs("idle_gap", 4'b0000, 1'b0, model_last);
                end
            end
            req = 4'($urandom_range(1, 15));
            run_txn(req, 4'b0001 << rr_pick(req, model_last), $urandom_range(0, 4),
                    $urandom_range(0, 4), ($urandom_range(0, 5) == 0), 1'($urandom),
                    1'($urandom));
        end

`ifdef BUS_ARB_WATCHDOG_EN
        bus.requestTransaction = 4'b0001;
        step();
        check_outs("wd_grant", 4'b0001, 1'b1, 0);
        model_last = 0;
        step();
        bus.beginTransactionIn = 1'b1;
        step();
        bus.beginTransactionIn = 1'b0;
        for (int i = 1; i < WD_CYC; i++) begin
            step();
            check_outs("wd_busy", 4'b0000, 1'b1, 0);
        end
        step();
        check("wd_fire.owned", 32'(bus.busOwned), 32'd0);
        check("wd_fire.pulses", {30'd0, bus.endTransactionOut, bus.busErrorOut}, 32'd3);
        check("wd_fire.flag", 32'(bus.watchdogFlag), 32'd1);
        exp_flag = 1'b1;
        step();
        check_outs("wd_after", 4'b0000, 1'b0, 0);
        run_txn(4'b1111, 4'b0010, 0, 1, 1'b0, 1'b0, 1'b0);
`endif

        #2 reset = 1'b0;
        exp_flag = 1'b0;
        #1;
        check_outs("final_reset", 4'b0000, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
